fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 32 +++
 rtl/fifo_uart_tx.sv | 139 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared types and constants for the FIFO-fed UART transmitter.
//   tx_state_e       : transmitter FSM states
//   DEF_DATA_WIDTH   : default payload width
//   DEF_CLKS_PER_BIT : default clock cycles per serial bit
//   IDLE_LVL         : line level while idle and during the stop bit
//   START_LVL        : line level of the start bit
package fifo_uart_pkg;

  localparam int   DEF_DATA_WIDTH   = 8;
  localparam int   DEF_CLKS_PER_BIT = 16;
  localparam logic IDLE_LVL         = 1'b1;
  localparam logic START_LVL        = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: prescale counter producing a one-cycle bit_done tick at the
// end of every CLKS_PER_BIT-cycle bit period.
//   clk      : clock
//   rst      : synchronous active-high reset
//   clear    : restart the bit period (asserted on a FIFO pop)
//   run      : count while a frame is in progress
//   bit_done : high in the last cycle of each bit period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic bit_done
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (run)
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign bit_done = run && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that pops words from a FIFO read port and
// serialises them as start / data (LSB first) / [parity] / stop.
// Define FIFO_UART_TX_PARITY_EN to include the parity bit; otherwise the
// frame goes straight from the last data bit to the stop bit and Par_Type
// is ignored.
//   R_CLK    : clock (FIFO read domain)
//   R_rst    : synchronous active-high reset
//   Empty    : FIFO empty flag; R_Data valid only while low
//   R_Data   : FIFO head word
//   Enable   : permission to start new frames
//   Par_Type : 0 even parity, 1 odd parity
//   R_inc    : one-cycle pop strobe to the FIFO
//   TX_OUT   : serial line, idle high
//   Busy     : high whenever a frame is in progress
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                  R_CLK,
  input  logic                  R_rst,
  input  logic                  Empty,
  input  logic [DATA_WIDTH-1:0] R_Data,
  input  logic                  Enable,
  input  logic                  Par_Type,
  output logic                  R_inc,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int            BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tx_state_e             state, next;
  logic                  pop;
  logic                  bit_done;
  logic [DATA_WIDTH-1:0] sreg;
  logic [BW-1:0]         bit_cnt;

`ifdef FIFO_UART_TX_PARITY_EN
  logic par_bit;

  // Parity is captured with the word so Par_Type changes mid-frame are inert.
  always_ff @(posedge R_CLK) begin
    if (R_rst)
      par_bit <= 1'b0;
    else if (pop)
      par_bit <= (^R_Data) ^ Par_Type;
  end
`else
  logic unused_par_type;
  assign unused_par_type = Par_Type;
`endif

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (R_CLK),
    .rst      (R_rst),
    .clear    (pop),
    .run      (state != IDLE),
    .bit_done (bit_done)
  );

  always_ff @(posedge R_CLK) begin
    if (R_rst)
      state <= IDLE;
    else
      state <= next;
  end

  always_comb begin
    next = state;
    pop  = 1'b0;
    case (state)
      IDLE:
        if (Enable && !Empty) begin
          pop  = 1'b1;
          next = START;
        end
      START:
        if (bit_done) next = DATA;
      DATA:
        if (bit_done && bit_cnt == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
          next = PARITY;
`else
          next = STOP;
`endif
        end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:
        if (bit_done) next = STOP;
`endif
      STOP:
        // Last stop cycle doubles as the pop cycle for back-to-back frames.
        if (bit_done) begin
          if (Enable && !Empty) begin
            pop  = 1'b1;
            next = START;
          end else begin
            next = IDLE;
          end
        end
      default:
        next = IDLE;
    endcase
    // A popped word would be lost under reset, so never pop then.
    if (R_rst) pop = 1'b0;
  end

  always_ff @(posedge R_CLK) begin
    if (R_rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      sreg    <= R_Data;
      bit_cnt <= '0;
    end else if (state == DATA && bit_done) begin
      sreg    <= sreg >> 1;
      bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
    end
  end

  always_comb begin
    TX_OUT = IDLE_LVL;
    case (state)
      START:  TX_OUT = START_LVL;
      DATA:   TX_OUT = sreg[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: TX_OUT = par_bit;
`endif
      default: TX_OUT = IDLE_LVL;
    endcase
  end

  assign R_inc = pop;
  assign Busy  = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx (DATA_WIDTH=8,
// CLKS_PER_BIT=16). Frame length follows FIFO_UART_TX_PARITY_EN.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 16;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int FB  = 1 + DW + PB + 1;
  localparam int FC  = FB * CPB;

  logic          R_CLK = 1'b0;
  logic          R_rst;
  logic          Empty;
  logic [DW-1:0] R_Data;
  logic          Enable;
  logic          Par_Type;
  logic          R_inc;
  logic          TX_OUT;
  logic          Busy;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .R_CLK    (R_CLK),
    .R_rst    (R_rst),
    .Empty    (Empty),
    .R_Data   (R_Data),
    .Enable   (Enable),
    .Par_Type (Par_Type),
    .R_inc    (R_inc),
    .TX_OUT   (TX_OUT),
    .Busy     (Busy)
  );

  always #5 R_CLK = ~R_CLK;

  task automatic tick();
    @(posedge R_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Expected line level for bit k of a frame carrying word w.
  function automatic logic exp_bit(input logic [DW-1:0] w, input logic pt, input int k);
    if (k == 0)                return 1'b0;
    if (k <= DW)               return w[k-1];
    if (PB == 1 && k == DW + 1) return (^w) ^ pt;
    return 1'b1;
  endfunction

  // Called in cycle 0 of a frame (just after the pop edge). Checks ncyc
  // cycles; pop_end expects R_inc in the final stop cycle; drop_at clears
  // Enable at that cycle.
  task automatic run_frame(input logic [DW-1:0] w, input logic pt, input bit pop_end,
                           input int drop_at, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      if (c == drop_at) begin Enable = 1'b0; #1; end
      chk("tx_bit", c, TX_OUT, exp_bit(w, pt, c / CPB));
      chk("busy",   c, Busy, 1'b1);
      chk("r_inc",  c, R_inc, (pop_end && c == FC - 1));
      tick();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"},   0, TX_OUT, 1'b1);
    chk({tag, "_busy"}, 0, Busy, 1'b0);
  endtask

  initial begin
    // Reset held 3 cycles with a non-empty FIFO and Enable high.
    R_rst = 1'b1; Empty = 1'b0; Enable = 1'b1; Par_Type = 1'b0; R_Data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rinc", i, R_inc, 1'b0);
      chk("rst_tx",   i, TX_OUT, 1'b1);
      chk("rst_busy", i, Busy, 1'b0);
    end
    Enable = 1'b0; R_rst = 1'b0;
    tick();
    chk_idle("idle0");
    chk("idle0_rinc", 0, R_inc, 1'b0);

    // Single frame 0xA5, even parity.
    R_Data = 8'hA5; Par_Type = 1'b0; Enable = 1'b1; #1;
    chk("pop_a5", 0, R_inc, 1'b1);
    tick();
    Empty = 1'b1; R_Data = 8'h00;
    run_frame(8'hA5, 1'b0, 1'b0, -1, FC);
    chk_idle("post_a5");
    chk("post_a5_rinc", 0, R_inc, 1'b0);

    // Odd parity, Par_Type flipped mid-frame must not matter.
    Empty = 1'b0; R_Data = 8'h07; Par_Type = 1'b1; #1;
    chk("pop_07", 0, R_inc, 1'b1);
    tick();
    Empty = 1'b1; Par_Type = 1'b0;
    run_frame(8'h07, 1'b1, 1'b0, -1, FC);
    chk_idle("post_07");

    // Back-to-back 0x01 then 0xFF; R_Data changing mid-frame is inert.
    Empty = 1'b0; R_Data = 8'h01; #1;
    chk("pop_01", 0, R_inc, 1'b1);
    tick();
    R_Data = 8'hFF;
    run_frame(8'h01, 1'b0, 1'b1, -1, FC);
    Empty = 1'b1; R_Data = 8'h00;
    run_frame(8'hFF, 1'b0, 1'b0, -1, FC);
    chk_idle("post_b2b");

    // Enable dropped at cycle 40 with FIFO still non-empty.
    Empty = 1'b0; Enable = 1'b1; R_Data = 8'h3C; #1;
    chk("pop_3c", 0, R_inc, 1'b1);
    tick();
    run_frame(8'h3C, 1'b0, 1'b0, 40, FC);
    for (int i = 0; i < 4; i++) begin
      chk_idle("en_drop");
      chk("en_drop_rinc", i, R_inc, 1'b0);
      tick();
    end

    // Reset during data bit 3 (frame bit 4), then a fresh pop.
    Enable = 1'b1; R_Data = 8'h96; #1;
    chk("pop_96", 0, R_inc, 1'b1);
    tick();
    run_frame(8'h96, 1'b0, 1'b0, -1, 4 * CPB + 5);
    R_rst = 1'b1; #1;
    chk("mid_rst_rinc", 0, R_inc, 1'b0);
    tick();
    chk_idle("mid_rst");
    chk("mid_rst_rinc2", 0, R_inc, 1'b0);
    R_rst = 1'b0; R_Data = 8'h55; #1;
    chk("pop_55", 0, R_inc, 1'b1);
    tick();
    Empty = 1'b1;
    run_frame(8'h55, 1'b0, 1'b0, -1, FC);
    chk_idle("post_55");

    // 0x80: last data bit is the only high one before parity/stop.
    Empty = 1'b0; R_Data = 8'h80; #1;
    chk("pop_80", 0, R_inc, 1'b1);
    tick();
    Empty = 1'b1;
    run_frame(8'h80, 1'b0, 1'b0, -1, FC);
    chk_idle("post_80");
    chk("post_80_rinc", 0, R_inc, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
